// File: rtl/arc_mem_arbiter.sv
// Round-robin arbiter sharing one ack-handshaked memory bus between instruction fetch and data load/store.
// Latency: request sampled in IDLE drives mem_req on the next edge; done pulses on the edge after ack is seen.
// Backpressure: requesters hold req until done; a slave ack that lingers is absorbed in RELEASE.
module arc_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          ack,
    output logic          busy,
    output logic          err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    state_t         state_q, state_nxt;
    logic           owner_q, owner_nxt;
    logic           last_owner_q, last_owner_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic           mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]  mem_addr_nxt;
    logic [DW-1:0]  mem_wdata_nxt;
    logic [DW-1:0]  if_rdata_nxt, d_rdata_nxt;
    logic           if_done_nxt, d_done_nxt, busy_nxt, err_nxt;
    logic           grant_data;
    logic           timeout_hit;

    // Data wins only when fetch is idle or fetch owned the bus last.
    assign grant_data  = d_req && (!if_req || (last_owner_q == OWN_FETCH));
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (if_req || d_req)        state_nxt = S_WAIT;
            S_WAIT:    if (ack || timeout_hit)     state_nxt = S_RELEASE;
            S_RELEASE: if (!ack)                   state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner_q;
        cnt_nxt        = cnt_q;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_rdata_nxt   = if_rdata;
        d_rdata_nxt    = d_rdata;
        if_done_nxt    = 1'b0;
        d_done_nxt     = 1'b0;
        err_nxt        = err;
        busy_nxt       = (state_nxt != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    owner_nxt     = grant_data;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = grant_data && d_we;
                    mem_addr_nxt  = grant_data ? d_addr : if_addr;
                    mem_wdata_nxt = d_wdata;
                    cnt_nxt       = '0;
                end
            end
            S_WAIT: begin
                cnt_nxt = CW'(cnt_q + 1'b1);
                if (ack || timeout_hit) begin
                    mem_req_nxt    = 1'b0;
                    last_owner_nxt = owner_q;
                    if (owner_q == OWN_DATA) d_done_nxt  = 1'b1;
                    else                     if_done_nxt = 1'b1;
                    if (ack) begin
                        if (!mem_we) begin
                            if (owner_q == OWN_DATA) d_rdata_nxt  = mem_rdata;
                            else                     if_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        err_nxt = 1'b1;
                        if (owner_q == OWN_DATA) d_rdata_nxt  = '0;
                        else                     if_rdata_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_DATA;
            cnt_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            owner_q      <= owner_nxt;
            last_owner_q <= last_owner_nxt;
            cnt_q        <= cnt_nxt;
            mem_req      <= mem_req_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            if_rdata     <= if_rdata_nxt;
            d_rdata      <= d_rdata_nxt;
            if_done      <= if_done_nxt;
            d_done       <= d_done_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_arc_mem_arbiter.sv
// Directed bench for arc_mem_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_arc_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          ack = 1'b0;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    arc_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ack(ack), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction at a time, then a hold-off until ack is low.
    bit            m_open, m_hold, m_last_data, m_own_data;
    int            m_age;
    logic          e_mem_req, e_mem_we, e_if_done, e_d_done, e_busy, e_err;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_open = 0; m_hold = 0; m_last_data = 1; m_own_data = 0; m_age = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
            e_if_rdata = '0; e_d_rdata = '0; e_if_done = 0; e_d_done = 0;
            e_busy = 0; e_err = 0;
        end else begin
            e_if_done = 0;
            e_d_done  = 0;
            if (m_open) begin
                m_age++;
                if (ack || m_age == TO) begin
                    m_open = 0; m_hold = 1; e_mem_req = 0; m_last_data = m_own_data;
                    if (m_own_data) e_d_done = 1; else e_if_done = 1;
                    if (ack) begin
                        if (!e_mem_we) begin
                            if (m_own_data) e_d_rdata = mem_rdata; else e_if_rdata = mem_rdata;
                        end
                    end else begin
                        e_err = 1;
                        if (m_own_data) e_d_rdata = '0; else e_if_rdata = '0;
                    end
                end
            end else if (m_hold) begin
                if (!ack) m_hold = 0;
            end else if (if_req || d_req) begin
                if (if_req && d_req) m_own_data = !m_last_data;
                else                 m_own_data = d_req;
                m_open = 1; m_age = 0; e_mem_req = 1;
                e_mem_we    = m_own_data && d_we;
                e_mem_addr  = m_own_data ? d_addr : if_addr;
                e_mem_wdata = d_wdata;
            end
            e_busy = m_open || m_hold;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("mem_req",   mem_req,   e_mem_req);
            check("mem_we",    mem_we,    e_mem_we);
            check("mem_addr",  mem_addr,  e_mem_addr);
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("if_rdata",  if_rdata,  e_if_rdata);
            check("d_rdata",   d_rdata,   e_d_rdata);
            check("if_done",   if_done,   e_if_done);
            check("d_done",    d_done,    e_d_done);
            check("busy",      busy,      e_busy);
            check("err",       err,       e_err);
        end
    end

    byte grants[$];

    task automatic note_done(input bit hold);
        if (if_done) begin grants.push_back("F"); if (!hold) if_req = 1'b0; end
        if (d_done)  begin grants.push_back("D"); if (!hold) d_req  = 1'b0; end
    endtask

    task automatic wait_req();
        int k = 0;
        while (mem_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("mem_req_rise", mem_req, 1'b1);
    endtask

    task automatic serve(input int delay, input int len, input logic [DW-1:0] data,
                         input bit hold, output int ndone);
        wait_req();
        repeat (delay) @(negedge clk);
        ack = 1'b1; mem_rdata = data; ndone = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (if_done || d_done) ndone++;
            note_done(hold);
        end
        ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);   check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0); check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_if_rdata"}, if_rdata, 0); check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_if_done"}, if_done, 0);   check({tag, "_d_done"}, d_done, 0);
        check({tag, "_busy"}, busy, 0);         check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int nd;
        int hi;
        int gap;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, ack 3 cycles after mem_req for 2 cycles
        if_addr = 32'h100; if_req = 1'b1;
        wait_req();
        check("t1_addr", mem_addr, 32'h100);
        check("t1_we", mem_we, 0);
        serve(3, 2, 32'hA5A5_0001, 0, nd);
        check("t1_ndone", nd, 1);
        check("t1_rdata", if_rdata, 32'hA5A5_0001);
        check("t1_busy_hold", busy, 1);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        repeat (2) @(negedge clk);

        // Store: bus carries store data, d_rdata untouched
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        wait_req();
        check("t2_we", mem_we, 1);
        check("t2_addr", mem_addr, 32'h200);
        check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        serve(1, 1, 32'h5555_5555, 0, nd);
        check("t2_ndone", nd, 1);
        check("t2_rdata_kept", d_rdata, 0);
        d_we = 1'b0;
        repeat (2) @(negedge clk);

        d_addr = 32'h204; d_req = 1'b1;
        serve(0, 1, 32'h1234_5678, 0, nd);
        check("load_rdata", d_rdata, 32'h1234_5678);
        repeat (2) @(negedge clk);

        // Tie right after reset: fetch first
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        grants.delete();
        if_addr = 32'h300; d_addr = 32'h400; if_req = 1'b1; d_req = 1'b1;
        serve(0, 1, 32'h0000_0A0A, 0, nd);
        serve(0, 1, 32'h0000_0B0B, 0, nd);
        check("t3_count", grants.size(), 2);
        check("t3_first", grants[0], "F");
        check("t3_second", grants[1], "D");
        repeat (2) @(negedge clk);

        // Both held continuously: strict alternation
        grants.delete();
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 4; i++) serve(0, 1, 32'h100 + i, 1, nd);
        if_req = 1'b0; d_req = 1'b0;
        check("t3_rr_count", grants.size(), 4);
        check("t3_rr0", grants[0], "F");
        check("t3_rr1", grants[1], "D");
        check("t3_rr2", grants[2], "F");
        check("t3_rr3", grants[3], "D");
        repeat (3) @(negedge clk);

        // Long ack: single done, next grant waits for ack to drop
        if_req = 1'b1; d_req = 1'b1;
        serve(0, 5, 32'hC0C0_C0C0, 0, nd);
        check("t5_ndone", nd, 1);
        check("t5_no_req", mem_req, 0);
        gap = 0;
        while (mem_req !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
        check("t5_gap", gap, 2);
        serve(0, 1, 32'hD0D0_D0D0, 0, nd);
        repeat (2) @(negedge clk);

        // Timeout on a data load
        check("t4_err_before", err, 0);
        d_addr = 32'h500; d_we = 1'b0; d_req = 1'b1;
        wait_req();
        hi = 1;
        for (int i = 0; i < 40 && mem_req; i++) begin
            @(negedge clk);
            if (mem_req) hi++;
        end
        check("t4_req_cycles", hi, TO);
        check("t4_done", d_done, 1);
        check("t4_rdata_zero", d_rdata, 0);
        check("t4_err", err, 1);
        note_done(0);
        repeat (2) @(negedge clk);
        if_addr = 32'h504; if_req = 1'b1;
        serve(1, 1, 32'hE0E0_E0E0, 0, nd);
        check("t4_err_sticky", err, 1);
        check("t4_after_rdata", if_rdata, 32'hE0E0_E0E0);
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT
        if_addr = 32'h600; if_req = 1'b1;
        wait_req();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("t6");
        if_req = 1'b0;
        @(negedge clk);
        check("t6_no_done", if_done, 0);
        rst = 1'b1;
        grants.delete();
        if_req = 1'b1; d_req = 1'b1;
        serve(1, 1, 32'hF0F0_F0F0, 0, nd);
        check("t6_first", grants[0], "F");
        check("t6_rdata", if_rdata, 32'hF0F0_F0F0);
        serve(0, 1, 32'hF1F1_F1F1, 0, nd);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
